// File: rtl/axi_cmd_arbiter_pkg.sv
// Shared types and status codes for the AXI4-Lite command arbiter and its master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        SETTLE = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4,
        DRAIN  = 3'd5
    } arb_state_t;

    // Status codes understood by both the arbiter and the AXI master.
    localparam logic [7:0] STATUS_OK         = 8'h00;
    localparam logic [7:0] STATUS_TIMEOUT    = 8'h04;
    localparam logic [7:0] STATUS_AXI_SLVERR = 8'h05;

endpackage

// File: rtl/axi_cmd_arbiter_rr_pick.sv
// Round-robin priority picker: first set request searching from last_grant+1 (mod NUM_REQ).
// Latency: purely combinational.
// Backpressure: none; found is low when no request is pending.
// Ports: req (request vector), last_grant (previous winner) -> found, idx (winner).
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int GIDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GIDX_W-1:0]  last_grant,
    output logic               found,
    output logic [GIDX_W-1:0]  idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Offset 1 first, so the previous winner is considered last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            int c;
            c = (int'(last_grant) + k) % NUM_REQ;
            if (!found && req[c]) begin
                found = 1'b1;
                idx   = GIDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/axi_cmd_arbiter.sv
// Shares one AXI4-Lite master command port among NUM_REQ requesters, round-robin, one txn at a time.
// Latency: req seen in IDLE -> m_start 1 cycle; m_done -> resp_valid 2 cycles (m_done is registered).
// Backpressure: requesters hold req_valid/cmd/addr until their resp_valid; a watchdog frees a hung master.
// Ports: req_valid/req_cmd/req_addr (flattened per requester) in; resp_valid/resp_status out;
//        grant_idx/grant_active for the data muxes; m_cmd/m_addr/m_start out, m_done/m_status in.
module axi_cmd_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int WATCHDOG_CYCLES = 4096,
    parameter int GIDX_W          = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*8-1:0]    req_cmd,
    input  logic [NUM_REQ*32-1:0]   req_addr,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [7:0]              resp_status,
    output logic [GIDX_W-1:0]       grant_idx,
    output logic                    grant_active,
    output logic [7:0]              m_cmd,
    output logic [31:0]             m_addr,
    output logic                    m_start,
    input  logic                    m_done,
    input  logic [7:0]              m_status
);

    localparam int WD_W = $clog2(WATCHDOG_CYCLES);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WATCHDOG_CYCLES - 1);

    arb_state_t          state_q, state_d;
    logic [GIDX_W-1:0]   last_grant_q, last_grant_d;
    logic [GIDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic                grant_active_q, grant_active_d;
    logic [7:0]          m_cmd_q, m_cmd_d;
    logic [31:0]         m_addr_q, m_addr_d;
    logic                m_start_q, m_start_d;
    logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
    logic [7:0]          resp_status_q, resp_status_d;
    logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
    logic                drain_q, drain_d;
    logic                m_done_q;
    logic [7:0]          m_status_q;

    logic                pick_found;
    logic [GIDX_W-1:0]   pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GIDX_W  (GIDX_W)
    ) u_rr_pick (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .found      (pick_found),
        .idx        (pick_idx)
    );

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        grant_idx_d    = grant_idx_q;
        grant_active_d = grant_active_q;
        m_cmd_d        = m_cmd_q;
        m_addr_d       = m_addr_q;
        m_start_d      = 1'b0;
        resp_valid_d   = '0;
        resp_status_d  = resp_status_q;
        wd_cnt_d       = wd_cnt_q;
        drain_d        = drain_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_idx_d    = pick_idx;
                    last_grant_d   = pick_idx;
                    m_cmd_d        = req_cmd[int'(pick_idx)*8 +: 8];
                    m_addr_d       = req_addr[int'(pick_idx)*32 +: 32];
                    m_start_d      = 1'b1;
                    grant_active_d = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: state_d = SETTLE;
            // The master may still show done from its previous transaction here.
            SETTLE: state_d = WAIT;
            WAIT: begin
                if (m_done_q) begin
                    resp_status_d           = m_status_q;
                    resp_valid_d[grant_idx_q] = 1'b1;
                    state_d                 = RESP;
                end else if (wd_cnt_q == WD_LIMIT) begin
                    resp_status_d           = STATUS_TIMEOUT;
                    resp_valid_d[grant_idx_q] = 1'b1;
                    drain_d                 = 1'b1;
                    state_d                 = RESP;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            RESP: begin
                wd_cnt_d       = '0;
                grant_active_d = 1'b0;
                state_d        = drain_q ? DRAIN : IDLE;
            end
            // Hold off new grants until the hung master finally reports done.
            DRAIN: begin
                if (m_done_q) begin
                    drain_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_grant_q   <= GIDX_W'(NUM_REQ - 1);
            grant_idx_q    <= '0;
            grant_active_q <= 1'b0;
            m_cmd_q        <= 8'h00;
            m_addr_q       <= 32'h0;
            m_start_q      <= 1'b0;
            resp_valid_q   <= '0;
            resp_status_q  <= STATUS_OK;
            wd_cnt_q       <= '0;
            drain_q        <= 1'b0;
            m_done_q       <= 1'b0;
            m_status_q     <= 8'h00;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            grant_idx_q    <= grant_idx_d;
            grant_active_q <= grant_active_d;
            m_cmd_q        <= m_cmd_d;
            m_addr_q       <= m_addr_d;
            m_start_q      <= m_start_d;
            resp_valid_q   <= resp_valid_d;
            resp_status_q  <= resp_status_d;
            wd_cnt_q       <= wd_cnt_d;
            drain_q        <= drain_d;
            m_done_q       <= m_done;
            m_status_q     <= m_status;
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_status  = resp_status_q;
    assign grant_idx    = grant_idx_q;
    assign grant_active = grant_active_q;
    assign m_cmd        = m_cmd_q;
    assign m_addr       = m_addr_q;
    assign m_start      = m_start_q;

endmodule

// File: tb/tb_axi_cmd_arbiter.sv
// Directed bench for axi_cmd_arbiter with two requesters and a short watchdog.
// Latency: inputs driven 1 time unit after posedge, outputs sampled at the same point.
// Backpressure: the bench plays the AXI master by hand (start -> clear done -> done after N cycles).
module tb_axi_cmd_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [15:0] req_cmd = '0;
    logic [63:0] req_addr = '0;
    logic [1:0]  resp_valid;
    logic [7:0]  resp_status;
    logic        grant_idx;
    logic        grant_active;
    logic [7:0]  m_cmd;
    logic [31:0] m_addr;
    logic        m_start;
    logic        m_done = 1'b0;
    logic [7:0]  m_status = '0;

    int n_checks = 0;
    int n_fail   = 0;

    axi_cmd_arbiter #(
        .NUM_REQ         (2),
        .WATCHDOG_CYCLES (64)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_cmd      (req_cmd),
        .req_addr     (req_addr),
        .resp_valid   (resp_valid),
        .resp_status  (resp_status),
        .grant_idx    (grant_idx),
        .grant_active (grant_active),
        .m_cmd        (m_cmd),
        .m_addr       (m_addr),
        .m_start      (m_start),
        .m_done       (m_done),
        .m_status     (m_status)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until m_start is seen (bounded) and checks how many cycles that took.
    task automatic wait_start(input string tag, input int exp_wait);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (m_start !== 1'b1 && n < 50);
        check_eq({tag, "_start_lat"}, 64'(n), 64'(exp_wait));
    endtask

    // One complete transaction with the bench acting as master.
    task automatic do_txn(input string tag, input int exp_wait, input logic exp_idx,
                          input logic [7:0] exp_cmd, input logic [31:0] exp_addr,
                          input int lat, input logic [7:0] status);
        int early;
        wait_start(tag, exp_wait);
        check_eq({tag, "_gidx"}, 64'(grant_idx), 64'(exp_idx));
        check_eq({tag, "_mcmd"}, 64'(m_cmd), 64'(exp_cmd));
        check_eq({tag, "_maddr"}, 64'(m_addr), 64'(exp_addr));
        check_eq({tag, "_gact"}, 64'(grant_active), 64'd1);
        tick();
        check_eq({tag, "_start_1cyc"}, 64'(m_start), 64'd0);
        m_done = 1'b0;              // master drops its old done after seeing start
        early = 0;
        repeat (lat) begin
            tick();
            if (resp_valid != 2'b00) early++;
        end
        check_eq({tag, "_no_early_resp"}, 64'(early), 64'd0);
        m_done   = 1'b1;
        m_status = status;
        tick();
        check_eq({tag, "_resp_not_yet"}, 64'(resp_valid), 64'd0);
        tick();
        check_eq({tag, "_resp_valid"}, 64'(resp_valid), 64'(exp_idx ? 2'b10 : 2'b01));
        check_eq({tag, "_resp_status"}, 64'(resp_status), 64'(status));
        check_eq({tag, "_gidx_in_resp"}, 64'(grant_idx), 64'(exp_idx));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check_eq({tag, "_resp_status"}, 64'(resp_status), 64'd0);
        check_eq({tag, "_gidx"}, 64'(grant_idx), 64'd0);
        check_eq({tag, "_gact"}, 64'(grant_active), 64'd0);
        check_eq({tag, "_mstart"}, 64'(m_start), 64'd0);
        check_eq({tag, "_mcmd"}, 64'(m_cmd), 64'd0);
        check_eq({tag, "_maddr"}, 64'(m_addr), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int n;
        int starts;

        req_cmd[7:0]   = 8'h80;  req_addr[31:0]  = 32'h0000_1000;
        req_cmd[15:8]  = 8'h01;  req_addr[63:32] = 32'h0000_2000;

        // Reset state
        tick();
        tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Single request from requester 0, master done after 10 cycles
        tick();
        req_valid = 2'b01;
        do_txn("single", 1, 1'b0, 8'h80, 32'h1000, 10, 8'h00);
        req_valid = 2'b00;
        tick();
        check_eq("single_idle_resp", 64'(resp_valid), 64'd0);
        check_eq("single_idle_gact", 64'(grant_active), 64'd0);

        // Both requesters held from reset; req0 re-requests at once
        rst_n = 1'b0;
        req_valid = 2'b11;
        tick();
        rst_n = 1'b1;
        do_txn("sim0", 1, 1'b0, 8'h80, 32'h1000, 4, 8'h00);
        // req0 stays high: treated as a new request, req1 must win
        do_txn("sim1", 2, 1'b1, 8'h01, 32'h2000, 3, 8'h05);
        req_valid = 2'b01;
        do_txn("sim0b", 2, 1'b0, 8'h80, 32'h1000, 2, 8'h00);

        // Watchdog: master never completes; req1 waits behind it
        req_cmd[7:0] = 8'h42;  req_addr[31:0] = 32'h0000_3000;
        wait_start("wd", 2);
        check_eq("wd_gidx", 64'(grant_idx), 64'd0);
        m_done = 1'b0;
        req_valid = 2'b11;
        n = 0;
        do begin
            tick();
            n++;
        end while (resp_valid == 2'b00 && n < 200);
        check_eq("wd_resp_lat", 64'(n), 64'd66);
        check_eq("wd_resp_valid", 64'(resp_valid), 64'h1);
        check_eq("wd_resp_status", 64'(resp_status), 64'h04);
        req_valid = 2'b10;
        starts = 0;
        repeat (20) begin
            tick();
            if (m_start) starts++;
        end
        check_eq("drain_no_start", 64'(starts), 64'd0);
        // Late done releases DRAIN; it stays high as a stale done into req1's txn
        m_done   = 1'b1;
        m_status = 8'h00;
        do_txn("stale", 3, 1'b1, 8'h01, 32'h2000, 5, 8'h00);
        req_valid = 2'b00;

        // Reset in the middle of WAIT
        req_valid = 2'b01;
        wait_start("pre_rst", 2);
        check_eq("pre_rst_gidx", 64'(grant_idx), 64'd0);
        tick();
        m_done = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        req_valid = 2'b11;
        tick();
        rst_n = 1'b1;
        wait_start("post_rst", 1);
        check_eq("post_rst_gidx", 64'(grant_idx), 64'd0);
        check_eq("post_rst_maddr", 64'(m_addr), 64'h3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
